// File: rtl/mem_access_unit_pkg.sv
// Shared types, funct3 codes and small helpers for the memory-stage load/store unit.
package mem_access_unit_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // RISC-V load/store width codes (stores use only the low two bits)
    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_INV = 3'b111;

    // Natural alignment for the access width; the reserved code never qualifies.
    function automatic logic access_aligned(input logic [2:0] funct3, input logic [2:0] off);
        logic ok;
        case (funct3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = (off[0] == 1'b0);
            2'b10:   ok = (off[1:0] == 2'b00);
            2'b11:   ok = (off == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok && (funct3 != F3_INV);
    endfunction

    // Byte-lane strobes for a store of the given width at the given lane offset.
    function automatic logic [7:0] store_strobe(input logic [2:0] funct3, input logic [2:0] off);
        logic [7:0] strb;
        case (funct3[1:0])
            2'b00:   strb = 8'h01 << off;
            2'b01:   strb = 8'h03 << off;
            2'b10:   strb = 8'h0F << off;
            2'b11:   strb = 8'hFF;
            default: strb = 8'h00;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the load/store unit and memory.
interface mem_access_unit_if #(
    parameter int DATA_W = 64
);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [7:0]        dmem_wstrb;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Lane-selects the addressed bytes of a returned doubleword and extends them.
module load_extend
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [2:0]        off,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] ext
);
    logic [DATA_W-1:0] shifted_s;

    // Shift the addressed lane down to bit 0, then sign- or zero-extend by width
    always_comb begin
        shifted_s = rdata >> {off, 3'b000};
        ext       = shifted_s;
        case (funct3)
            F3_B:    ext = {{(DATA_W-8){shifted_s[7]}},   shifted_s[7:0]};
            F3_H:    ext = {{(DATA_W-16){shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    ext = {{(DATA_W-32){shifted_s[31]}}, shifted_s[31:0]};
            F3_D:    ext = shifted_s;
            F3_BU:   ext = {{(DATA_W-8){1'b0}},  shifted_s[7:0]};
            F3_HU:   ext = {{(DATA_W-16){1'b0}}, shifted_s[15:0]};
            F3_WU:   ext = {{(DATA_W-32){1'b0}}, shifted_s[31:0]};
            default: ext = '0;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues req/gnt/rvalid transactions, stalls the
// pipeline while one is outstanding, flags misaligned accesses and bus timeouts.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               memRead_in,
    input  logic               memWrite_in,
    input  logic [2:0]         funct3_in,
    input  logic [DATA_W-1:0]  addr_in,
    input  logic [DATA_W-1:0]  writeData_in,
    mem_access_unit_if.master  dmem,
    output logic [DATA_W-1:0]  readData_out,
    output logic               stall_out,
    output logic               misaligned_out,
    output logic               busErr_out
);
    // Counter holds up to TIMEOUT: a load granted on the last REQ cycle enters RESP at TIMEOUT.
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    lsu_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        wstrb_q, wstrb_d;
    logic [2:0]        off_q, off_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] read_q, read_d;
    logic              berr_q, berr_d;

    logic              access_s;
    logic              aligned_s;
    logic [2:0]        off_in_s;
    logic [DATA_W-1:0] ext_s;

    assign access_s  = memRead_in | memWrite_in;
    assign off_in_s  = addr_in[2:0];
    assign aligned_s = access_aligned(funct3_in, off_in_s);

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .rdata  (dmem.dmem_rdata),
        .off    (off_q),
        .funct3 (funct3_q),
        .ext    (ext_s)
    );

    // Next-state, request latching, timeout counting and combinational stall/misalign
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        off_d          = off_q;
        funct3_d       = funct3_q;
        cnt_d          = cnt_q;
        read_d         = read_q;
        berr_d         = 1'b0;
        stall_out      = 1'b0;
        misaligned_out = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (access_s && aligned_s) begin
                    stall_out = 1'b1;
                    state_d   = LSU_REQ;
                    req_d     = 1'b1;
                    we_d      = memWrite_in;
                    addr_d    = {addr_in[DATA_W-1:3], 3'b000};
                    off_d     = off_in_s;
                    funct3_d  = funct3_in;
                    cnt_d     = '0;
                    if (memWrite_in) begin
                        wdata_d = writeData_in << {off_in_s, 3'b000};
                        wstrb_d = store_strobe(funct3_in, off_in_s);
                    end else begin
                        wdata_d = '0;
                        wstrb_d = 8'h00;
                    end
                end else if (access_s) begin
                    misaligned_out = 1'b1;
                end else begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_REQ: begin
                stall_out = 1'b1;
                if (dmem.dmem_gnt) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = we_q ? LSU_DONE : LSU_RESP;
                end else if (cnt_q >= CNT_LAST) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    read_d  = '0;
                    berr_d  = 1'b1;
                    state_d = LSU_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LSU_RESP: begin
                stall_out = 1'b1;
                if (dmem.dmem_rvalid) begin
                    read_d  = ext_s;
                    state_d = LSU_DONE;
                end else if (cnt_q >= CNT_LAST) begin
                    read_d  = '0;
                    berr_d  = 1'b1;
                    state_d = LSU_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    // State and registered bus/result outputs; async reset abandons any transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= LSU_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= 8'h00;
            off_q    <= 3'b000;
            funct3_q <= 3'b000;
            cnt_q    <= '0;
            read_q   <= '0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            off_q    <= off_d;
            funct3_q <= funct3_d;
            cnt_q    <= cnt_d;
            read_q   <= read_d;
            berr_q   <= berr_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_wstrb = wstrb_q;
    assign readData_out    = read_q;
    assign busErr_out      = berr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, timeout and
// reset sequences, and randomized accesses against a byte-level reference model.
module tb_mem_access_unit;
    localparam int DW  = 64;
    localparam int TMO = 8;

    logic          clk, reset;
    logic          memRead_in, memWrite_in;
    logic [2:0]    funct3_in;
    logic [63:0]   addr_in, writeData_in, readData_out;
    logic          stall_out, misaligned_out, busErr_out;

    mem_access_unit_if #(.DATA_W(DW)) bus ();

    mem_access_unit #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .memRead_in     (memRead_in),
        .memWrite_in    (memWrite_in),
        .funct3_in      (funct3_in),
        .addr_in        (addr_in),
        .writeData_in   (writeData_in),
        .dmem           (bus),
        .readData_out   (readData_out),
        .stall_out      (stall_out),
        .misaligned_out (misaligned_out),
        .busErr_out     (busErr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] last_rd;

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [63:0] a, wd, rdat;
        int          gd, rvd;       // grant / rvalid wait cycles, -1 = never
        bit          early;         // spurious rvalid in the grant cycle
        logic        mis;
        logic [63:0] exp_rd;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wdata;
        int          exp_stall;
        logic        exp_err;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---- reference model: byte lanes and plain arithmetic ----
    function automatic logic m_aligned(input logic [2:0] f3, input logic [63:0] a);
        int sz;
        sz = 1 << f3[1:0];
        return (f3 != 3'd7) && ((int'(a[2:0]) % sz) == 0);
    endfunction

    function automatic logic [7:0] m_strb(input logic [2:0] f3, input logic [63:0] a);
        int n, off;
        logic [7:0] s;
        n = 1 << f3[1:0];
        off = int'(a[2:0]);
        s = 8'h00;
        for (int i = 0; i < 8; i++) if (i >= off && i < off + n) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] wd, input logic [63:0] a);
        int off;
        logic [63:0] o;
        off = int'(a[2:0]);
        o = 64'h0;
        for (int i = 0; i + off < 8; i++) o[8*(i+off) +: 8] = wd[8*i +: 8];
        return o;
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] rdat);
        int n, off;
        logic [63:0] v;
        n = 1 << f3[1:0];
        off = int'(a[2:0]);
        v = 64'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rdat[8*(off+i) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1]) for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    // One pipeline access with the bench acting as memory; entered and left at negedge+1.
    task automatic run_access(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rdat,
                              input int gd, input int rvd, input bit early, input logic mis,
                              input logic [63:0] exp_rdout, input logic [7:0] exp_strb,
                              input logic [63:0] exp_wdata, input int exp_stall, input logic exp_err);
        int cyc, stalls, gw, rw;
        bit phase, done;
        logic [63:0] exp_r;
        memRead_in = rd; memWrite_in = wr; funct3_in = f3; addr_in = a; writeData_in = wd;
        #1;
        chk({nm, " misaligned"}, misaligned_out, mis);
        if (mis) begin
            chk({nm, " mis stall"}, stall_out, 1'b0);
            chk({nm, " mis req"}, bus.dmem_req, 1'b0);
            memRead_in = 1'b0; memWrite_in = 1'b0;
            @(negedge clk); #1;
            chk({nm, " mis req after"}, bus.dmem_req, 1'b0);
            chk({nm, " mis readData"}, readData_out, last_rd);
            return;
        end
        cyc = 0; stalls = 0; gw = 0; rw = 0; phase = 1'b0; done = 1'b0;
        while (!done) begin
            if (cyc > 0 && !stall_out) begin
                done = 1'b1;
            end else begin
                if (stall_out) stalls++;
                if (phase) chk({nm, " req after gnt"}, bus.dmem_req, 1'b0);
                if (bus.dmem_req) begin
                    chk({nm, " addr"},  bus.dmem_addr,  a & ~64'h7);
                    chk({nm, " we"},    bus.dmem_we,    wr);
                    chk({nm, " wstrb"}, bus.dmem_wstrb, exp_strb);
                    chk({nm, " wdata"}, bus.dmem_wdata, exp_wdata);
                    if (gd >= 0 && gw == gd) begin
                        bus.dmem_gnt = 1'b1; phase = 1'b1;
                        bus.dmem_rvalid = early; bus.dmem_rdata = ~rdat;
                    end else begin
                        bus.dmem_gnt = 1'b0; gw++;
                        bus.dmem_rvalid = 1'b0; bus.dmem_rdata = {$urandom, $urandom};
                    end
                end else begin
                    bus.dmem_gnt = 1'b0;
                    if (phase && rd && rvd >= 0 && rw == rvd) begin
                        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rdat;
                    end else begin
                        bus.dmem_rvalid = 1'b0; bus.dmem_rdata = {$urandom, $urandom};
                        if (phase) rw++;
                    end
                end
                @(negedge clk); #1;
                cyc++;
                if (cyc > 60) begin
                    checks++; errors++;
                    $display("FAIL %s: cycle budget expired, stall still %0b, required completion", nm, stall_out);
                    done = 1'b1;
                end
            end
        end
        exp_r = exp_err ? 64'h0 : (rd ? exp_rdout : last_rd);
        chk({nm, " stall cycles"}, 64'(stalls), 64'(exp_stall));
        chk({nm, " busErr"},       busErr_out,   exp_err);
        chk({nm, " readData"},     readData_out, exp_r);
        chk({nm, " req in done"},  bus.dmem_req, 1'b0);
        last_rd = exp_r;
        memRead_in = 1'b0; memWrite_in = 1'b0;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
        @(negedge clk); #1;
        chk({nm, " busErr pulse end"}, busErr_out,   1'b0);
        chk({nm, " readData stable"},  readData_out, last_rd);
        chk({nm, " idle stall"},       stall_out,    1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        isw;
        logic [2:0]  f3;
        logic [63:0] a, wd, rdat;
        int          gd, rvd, sz;
        logic        mis;

        tbl[0]  = '{1,0,3'd3,64'h100,64'h0,64'h1122334455667788,0,0,0,0,64'h1122334455667788,8'h00,64'h0,3,0};
        tbl[1]  = '{1,0,3'd0,64'h103,64'h0,64'h0000000080000000,0,0,0,0,64'hFFFFFFFFFFFFFF80,8'h00,64'h0,3,0};
        tbl[2]  = '{1,0,3'd4,64'h103,64'h0,64'h0000000080000000,0,0,0,0,64'h0000000000000080,8'h00,64'h0,3,0};
        tbl[3]  = '{0,1,3'd1,64'h106,64'hABCD,64'h0,2,0,0,0,64'h0,8'hC0,64'hABCD000000000000,4,0};
        tbl[4]  = '{1,0,3'd2,64'h102,64'h0,64'h0,0,0,0,1,64'h0,8'h00,64'h0,0,0};
        tbl[5]  = '{1,0,3'd7,64'h100,64'h0,64'h0,0,0,0,1,64'h0,8'h00,64'h0,0,0};
        tbl[6]  = '{1,0,3'd1,64'h10A,64'h0,64'h123456789ABCDEF0,0,0,0,0,64'hFFFFFFFFFFFF9ABC,8'h00,64'h0,3,0};
        tbl[7]  = '{1,0,3'd6,64'h108,64'h0,64'h123456789ABCDEF0,1,2,0,0,64'h000000009ABCDEF0,8'h00,64'h0,6,0};
        tbl[8]  = '{1,0,3'd2,64'h10C,64'h0,64'h123456789ABCDEF0,3,3,0,0,64'h0000000012345678,8'h00,64'h0,9,0};
        tbl[9]  = '{0,1,3'd0,64'h107,64'h5A,64'h0,0,0,0,0,64'h0,8'h80,64'h5A00000000000000,2,0};
        tbl[10] = '{0,1,3'd2,64'h104,64'hDEADBEEFCAFEF00D,64'h0,1,0,0,0,64'h0,8'hF0,64'hCAFEF00D00000000,3,0};
        tbl[11] = '{0,1,3'd3,64'h1F8,64'h0123456789ABCDEF,64'h0,0,0,0,0,64'h0,8'hFF,64'h0123456789ABCDEF,2,0};
        tbl[12] = '{1,0,3'd3,64'h108,64'h0,64'hFEDCBA9876543210,0,1,1,0,64'hFEDCBA9876543210,8'h00,64'h0,4,0};
        tbl[13] = '{1,0,3'd5,64'h10E,64'h0,64'h123456789ABCDEF0,0,0,0,0,64'h0000000000001234,8'h00,64'h0,3,0};
        tbl[14] = '{1,0,3'd6,64'h200,64'h0,64'h0,-1,0,0,0,64'h0,8'h00,64'h0,9,1};
        tbl[15] = '{1,0,3'd3,64'h208,64'h0,64'h0,0,-1,0,0,64'h0,8'h00,64'h0,9,1};
        tbl[16] = '{0,1,3'd2,64'h20C,64'h1,64'h0,-1,0,0,0,64'h0,8'hF0,64'h0000000100000000,9,1};

        reset = 1'b0;
        memRead_in = 1'b0; memWrite_in = 1'b0; funct3_in = 3'd0; addr_in = 64'h0; writeData_in = 64'h0;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 64'h0;
        last_rd = 64'h0;

        @(negedge clk); #1;
        chk("reset req",       bus.dmem_req,   1'b0);
        chk("reset we",        bus.dmem_we,    1'b0);
        chk("reset addr",      bus.dmem_addr,  64'h0);
        chk("reset wdata",     bus.dmem_wdata, 64'h0);
        chk("reset wstrb",     bus.dmem_wstrb, 8'h00);
        chk("reset readData",  readData_out,   64'h0);
        chk("reset busErr",    busErr_out,     1'b0);
        chk("reset stall",     stall_out,      1'b0);
        chk("reset misalign",  misaligned_out, 1'b0);
        reset = 1'b1;
        @(negedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            run_access($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd,
                       tbl[i].rdat, tbl[i].gd, tbl[i].rvd, tbl[i].early, tbl[i].mis, tbl[i].exp_rd,
                       tbl[i].exp_strb, tbl[i].exp_wdata, tbl[i].exp_stall, tbl[i].exp_err);
        end

        // Reset while a load waits in RESP: request and stall drop immediately.
        memRead_in = 1'b1; funct3_in = 3'd3; addr_in = 64'h300;
        @(negedge clk); #1;
        chk("rst_seq req", bus.dmem_req, 1'b1);
        bus.dmem_gnt = 1'b1;
        @(negedge clk); #1;
        bus.dmem_gnt = 1'b0;
        chk("rst_seq resp stall", stall_out, 1'b1);
        #2;
        reset = 1'b0;
        memRead_in = 1'b0;
        #1;
        chk("rst_seq req low",   bus.dmem_req, 1'b0);
        chk("rst_seq stall low", stall_out,    1'b0);
        chk("rst_seq readData",  readData_out, 64'h0);
        last_rd = 64'h0;
        @(negedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        run_access("post_reset_sd", 1'b0, 1'b1, 3'd3, 64'h3F0, 64'h8877665544332211, 64'h0, 0, 0, 1'b0,
                   1'b0, 64'h0, 8'hFF, 64'h8877665544332211, 2, 1'b0);

        // Randomized accesses against the reference model.
        for (int k = 0; k < 60; k++) begin
            isw = 1'($urandom_range(0, 1));
            if (isw) f3 = ($urandom_range(0, 5) == 5) ? 3'd7 : 3'($urandom_range(0, 3));
            else     f3 = 3'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            sz = 1 << f3[1:0];
            if ($urandom_range(0, 2) != 0) a = a & ~(64'(sz - 1));
            wd = {$urandom, $urandom};
            rdat = {$urandom, $urandom};
            gd = $urandom_range(0, 3);
            rvd = $urandom_range(0, 3);
            mis = !m_aligned(f3, a);
            run_access($sformatf("rnd%0d", k), !isw, isw, f3, a, wd, rdat, gd, rvd,
                       1'($urandom_range(0, 1)), mis, m_load(f3, a, rdat),
                       isw ? m_strb(f3, a) : 8'h00, isw ? m_wdata(wd, a) : 64'h0,
                       isw ? (2 + gd) : (3 + gd + rvd), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit of the pipelined core, between EX_MEM and the MEM/WB register. Turns the stage's memRead/memWrite request into a req/gnt/rvalid data-memory transaction, builds byte strobes and lane-aligned store data, and extracts and sign/zero-extends load data into `readData`. It stalls the pipeline while a transaction is outstanding, and it flags misaligned accesses and bus timeouts.

## Interface
- `DATA_W`, default 64: data/address width; equals `` `DataBusBits ``.
- `TIMEOUT`, default 255: maximum cycles spent in REQ+RESP before a bus error.
- `clk` input 1: the single clock.
- `reset` input 1: one clock; reset is asynchronous and active-low.
- `memRead_in` input 1: stage holds a load.
- `memWrite_in` input 1: stage holds a store; never set together with `memRead_in`.
- `funct3_in` input 3: RISC-V width/sign code.
- `addr_in` input DATA_W: effective address (ALUResult).
- `writeData_in` input DATA_W: store source, LSB-aligned.
- `dmem_req` output 1: request valid.
- `dmem_we` output 1: write request.
- `dmem_addr` output DATA_W: doubleword-aligned address (`addr[2:0]` = 0).
- `dmem_wdata` output DATA_W: lane-shifted store data.
- `dmem_wstrb` output 8: byte strobes.
- `dmem_gnt` input 1: request accepted.
- `dmem_rvalid` input 1: load data valid.
- `dmem_rdata` input DATA_W: load data.
- `readData_out` output DATA_W: extended load result, to MEM_WB `readData_in`.
- `stall_out` output 1: freeze PC, IF_ID, ID_EX, EX_MEM; bubble into MEM_WB is not inserted, MEM_WB holds.
- `misaligned_out` output 1: misaligned access, no bus request issued.
- `busErr_out` output 1: one-cycle pulse on timeout completion.

## Operation
- FSM states: IDLE, REQ, RESP, DONE. Reset state is IDLE. All registered outputs reset to 0: `dmem_*`, `readData_out`, `busErr_out`.
- access = `memRead_in | memWrite_in`.
- aligned: byte always; half needs `addr[0]`=0; word needs `addr[1:0]`=0; dword needs `addr[2:0]`=0.
- IDLE:
  - With access & !aligned: `misaligned_out`=1 (combinational), no stall, stay IDLE.
  - With access & aligned: latch request registers, go to REQ.
- REQ:
  - `dmem_req`=1; addr, we, wdata and wstrb are held stable until `dmem_gnt`.
  - On gnt, a store goes to DONE and a load goes to RESP.
- RESP:
  - On `dmem_rvalid`, capture the extracted data into `readData_out` and go to DONE.
  - An rvalid arriving in the same cycle as gnt is ignored; the response is accepted only in RESP.
- DONE: lasts one cycle, then IDLE. The instruction leaves the stage on this edge.
- `stall_out` = (IDLE & access & aligned) | REQ | RESP. It is 0 in DONE, so the same instruction is not retriggered.
- Strobes, with off = `addr[2:0]`:
  - sb: `1<<off`
  - sh: `3<<off`
  - sw: `0x0F<<off`
  - sd: `0xFF`
- `dmem_wdata` = `writeData_in << (8*off)`.
- Load extraction from `dmem_rdata >> (8*off)`:
  - lb/lh/lw sign-extend from 8/16/32 bits.
  - lbu/lhu/lwu zero-extend.
  - ld passes through.
  - `funct3` 3'b111 counts as invalid: it is treated as misaligned.
- Timeout counter:
  - Cleared on entering REQ; counts in REQ and RESP.
  - On reaching TIMEOUT: go to DONE, `dmem_req` drops, `readData_out`=0, `busErr_out`=1 during DONE.
- Asynchronous reset mid-transaction returns to IDLE and drops `dmem_req` at once. The memory side must discard any in-flight response.

## Timing
- Load, gnt in the first REQ cycle, rvalid the next cycle:
  - Access seen at cycle T; REQ at T+1; RESP at T+2; DONE at T+3.
  - Stall is high for T..T+2 (3 cycles); MEM_WB captures at the end of T+3.
- Store with immediate gnt: stall for T..T+1 (2 cycles); DONE at T+2.
- Each gnt-wait or rvalid-wait cycle adds one stall cycle.
- `readData_out` is stable from DONE until the next load completes.
- Misaligned access or no access: zero added latency.

## Structure
- `` `DataBusBits `` and `` `DataZero `` come from `diagv2_const.vh`.
- Add to `diagv2_const.vh`:
  - FSM state encodings: `` `LsuIdle ``, `` `LsuReq ``, `` `LsuResp ``, `` `LsuDone ``.
  - funct3 load/store codes.
- One sub-module: `load_extend`, combinational; inputs rdata, off, funct3; output the extended value.

## Test plan
- `ld` at 0x100, gnt first cycle, rdata=0x1122334455667788 next cycle -> `dmem_addr`=0x100, `readData_out`=0x1122334455667788, stall exactly 3 cycles.
- `lb` at 0x103, rdata=0x00000000_80000000 -> `readData_out`=0xFFFFFFFFFFFFFF80; `lbu` on the same data -> 0x80.
- `sh` at 0x106, writeData=0xABCD, gnt delayed 2 cycles -> `dmem_wstrb`=0xC0, `dmem_wdata[63:48]`=0xABCD, request held stable, stall 4 cycles.
- `lw` at 0x102 -> `misaligned_out`=1, `dmem_req` never asserted, `stall_out`=0.
- `lwu` with gnt never asserted, TIMEOUT=8 -> DONE after 8 cycles, `busErr_out` pulses once, `readData_out`=0.
- Reset asserted while in RESP -> `dmem_req`=0, `stall_out`=0, state IDLE immediately; a following `sd` completes normally.
